// File: rtl/bit_stuff_counter.sv
// Receive-path run-length / stuff-position tracker feeding the CAN XL stuff-error monitor.
// Define FIXED_STUFF_EN to include the fixed-stuffing (FIX) region logic.
module bit_stuff_counter #(
  parameter int FIXED_PERIOD = 15
) (
  input  logic        clk,
  input  logic        g_rst_n,
  input  logic        bit_valid,
  input  logic        serial_in,
  input  logic        sof,
  input  logic        dyn_stf_en,
  input  logic        fix_stf_en,
  input  logic        frame_end,
  output logic [2:0]  one_count,
  output logic [2:0]  zero_count,
  output logic [2:0]  one_count1,
  output logic [2:0]  zero_count1,
  output logic [4:0]  bit_count,
  output logic [14:0] rcvd_bt_cnt,
  output logic        stuff_bit,
  output logic        data_out,
  output logic        data_valid
);

  typedef enum logic [1:0] {IDLE, DYN, FIX} state_t;

  state_t state_q, state_d;
  logic   clr_all, clr_run;

  always_ff @(posedge clk or negedge g_rst_n)
    if (!g_rst_n) state_q <= IDLE;
    else          state_q <= state_d;

  // The bit strobed this cycle is handled under state_d's rules, so a mode
  // change takes effect on the coincident bit.
  always_comb begin
    state_d = state_q;
    clr_all = 1'b0;
    if (sof) begin
      state_d = DYN;
      clr_all = 1'b1;
    end else if (frame_end) begin
      state_d = IDLE;
    end else if (state_q != IDLE) begin
`ifdef FIXED_STUFF_EN
      if (fix_stf_en)      state_d = FIX;
      else if (dyn_stf_en) state_d = DYN;
`else
      if (dyn_stf_en)      state_d = DYN;
`endif
    end
    clr_run = clr_all ||
              ((state_d != state_q) && (state_d != IDLE) &&
               ((state_d == FIX) || (state_q == FIX)));
  end

  logic [2:0]  oc_b, zc_b, oc_n, zc_n;
  logic [2:0]  oc1_b, zc1_b, oc1_n, zc1_n;
  logic [4:0]  bc_b, bc_n;
  logic [14:0] rc_b, rc_n;
  logic        stf_n, dv_n, dout_n;

  always_comb begin
    oc_b   = clr_run ? 3'd0  : one_count;
    zc_b   = clr_run ? 3'd0  : zero_count;
    oc1_b  = clr_run ? 3'd0  : one_count1;
    zc1_b  = clr_run ? 3'd0  : zero_count1;
    bc_b   = clr_run ? 5'd0  : bit_count;
    rc_b   = clr_all ? 15'd0 : rcvd_bt_cnt;
    oc_n   = oc_b;
    zc_n   = zc_b;
    oc1_n  = oc1_b;
    zc1_n  = zc1_b;
    bc_n   = bc_b;
    rc_n   = rc_b;
    stf_n  = 1'b0;
    dv_n   = 1'b0;
    dout_n = data_out;
    if (bit_valid && state_d == DYN) begin
      if (oc_b == 3'd5 || zc_b == 3'd5) begin
        // Run restarts with the stuff bit's own polarity, right or wrong.
        stf_n = 1'b1;
        oc_n  = serial_in ? 3'd1 : 3'd0;
        zc_n  = serial_in ? 3'd0 : 3'd1;
      end else begin
        dv_n   = 1'b1;
        dout_n = serial_in;
        oc_n   = serial_in ? oc_b + 3'd1 : 3'd0;
        zc_n   = serial_in ? 3'd0 : zc_b + 3'd1;
        rc_n   = (rc_b == 15'h7fff) ? rc_b : rc_b + 15'd1;
      end
    end
`ifdef FIXED_STUFF_EN
    else if (bit_valid && state_d == FIX) begin
      if (bc_b == 5'(FIXED_PERIOD)) begin
        stf_n = 1'b1;
        bc_n  = 5'd0;
      end else begin
        dv_n   = 1'b1;
        dout_n = serial_in;
        bc_n   = bc_b + 5'd1;
        oc1_n  = serial_in ? ((oc1_b == 3'd7) ? oc1_b : oc1_b + 3'd1) : 3'd0;
        zc1_n  = serial_in ? 3'd0 : ((zc1_b == 3'd7) ? zc1_b : zc1_b + 3'd1);
        rc_n   = (rc_b == 15'h7fff) ? rc_b : rc_b + 15'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge g_rst_n)
    if (!g_rst_n) begin
      one_count   <= '0;
      zero_count  <= '0;
      rcvd_bt_cnt <= '0;
      stuff_bit   <= 1'b0;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      one_count   <= oc_n;
      zero_count  <= zc_n;
      rcvd_bt_cnt <= rc_n;
      stuff_bit   <= stf_n;
      data_out    <= dout_n;
      data_valid  <= dv_n;
    end

`ifdef FIXED_STUFF_EN
  always_ff @(posedge clk or negedge g_rst_n)
    if (!g_rst_n) begin
      one_count1  <= '0;
      zero_count1 <= '0;
      bit_count   <= '0;
    end else begin
      one_count1  <= oc1_n;
      zero_count1 <= zc1_n;
      bit_count   <= bc_n;
    end
`else
  assign one_count1  = '0;
  assign zero_count1 = '0;
  assign bit_count   = '0;

  // Fixed-region inputs have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = fix_stf_en ^ FIXED_PERIOD[0] ^ (|oc1_n) ^ (|zc1_n) ^ (|bc_n);
`endif

endmodule

// File: tb/tb_bit_stuff_counter.sv
// Scoreboard bench for bit_stuff_counter: directed bit sequences with hand-computed results.
module tb_bit_stuff_counter;

  logic        clk = 1'b0, g_rst_n = 1'b0;
  logic        bit_valid = 1'b0, serial_in = 1'b0, sof = 1'b0;
  logic        dyn_stf_en = 1'b0, fix_stf_en = 1'b0, frame_end = 1'b0;
  logic [2:0]  one_count, zero_count, one_count1, zero_count1;
  logic [4:0]  bit_count;
  logic [14:0] rcvd_bt_cnt;
  logic        stuff_bit, data_out, data_valid;

  bit_stuff_counter #(.FIXED_PERIOD(15)) dut (
    .clk(clk), .g_rst_n(g_rst_n), .bit_valid(bit_valid), .serial_in(serial_in),
    .sof(sof), .dyn_stf_en(dyn_stf_en), .fix_stf_en(fix_stf_en), .frame_end(frame_end),
    .one_count(one_count), .zero_count(zero_count), .one_count1(one_count1),
    .zero_count1(zero_count1), .bit_count(bit_count), .rcvd_bt_cnt(rcvd_bt_cnt),
    .stuff_bit(stuff_bit), .data_out(data_out), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stf;
    logic        dout;
    logic [2:0]  oc, zc, oc1, zc1;
    logic [4:0]  bc;
    logic [14:0] rc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;

  // Monitor: every stuff/data pulse must match the oldest expected response.
  initial forever begin
    @(negedge clk);
    if (g_rst_n && (data_valid || stuff_bit)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output stuff_bit=%0b data_valid=%0b", stuff_bit, data_valid);
      end else begin
        mon_e = exp_q.pop_front();
        if (stuff_bit !== mon_e.stf || data_valid !== !mon_e.stf ||
            (!mon_e.stf && data_out !== mon_e.dout) ||
            one_count !== mon_e.oc || zero_count !== mon_e.zc ||
            one_count1 !== mon_e.oc1 || zero_count1 !== mon_e.zc1 ||
            bit_count !== mon_e.bc || rcvd_bt_cnt !== mon_e.rc) begin
          n_fail++;
          $display("FAIL bit_result actual stf=%0b dv=%0b d=%0b oc=%0d zc=%0d oc1=%0d zc1=%0d bc=%0d rc=%0d required stf=%0b d=%0b oc=%0d zc=%0d oc1=%0d zc1=%0d bc=%0d rc=%0d",
                   stuff_bit, data_valid, data_out, one_count, zero_count, one_count1,
                   zero_count1, bit_count, rcvd_bt_cnt, mon_e.stf, mon_e.dout, mon_e.oc,
                   mon_e.zc, mon_e.oc1, mon_e.zc1, mon_e.bc, mon_e.rc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {one_count, zero_count, one_count1, zero_count1, bit_count, rcvd_bt_cnt,
            stuff_bit, data_out, data_valid};
  endfunction

  // Called at posedge+1; strobes one bit and queues its expected result.
  task automatic bit_in(input logic b, input logic stf, input int oc, input int zc,
                        input int oc1, input int zc1, input int bc, input int rc);
    exp_t e;
    e.stf = stf; e.dout = b;
    e.oc = 3'(oc); e.zc = 3'(zc); e.oc1 = 3'(oc1); e.zc1 = 3'(zc1);
    e.bc = 5'(bc); e.rc = 15'(rc);
    exp_q.push_back(e);
    bit_valid = 1'b1; serial_in = b;
    @(posedge clk); #1;
    bit_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #12;
    chk("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    g_rst_n = 1'b1;

    // Five 1s, stuff 0, then data 1.
    sof = 1'b1; dyn_stf_en = 1'b1;
    for (int k = 1; k <= 5; k++) bit_in(1'b1, 1'b0, k, 0, 0, 0, 0, k);
    bit_in(1'b0, 1'b1, 0, 1, 0, 0, 0, 5);
    bit_in(1'b1, 1'b0, 1, 0, 0, 0, 0, 6);
    idle_cycles(1);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    // Strobes in IDLE must be ignored.
    bit_valid = 1'b1; serial_in = 1'b0;
    idle_cycles(2);
    bit_valid = 1'b0;
    idle_cycles(1);
    chk("idle_hold_one_count", one_count, 1);
    chk("idle_hold_zero_count", zero_count, 0);
    chk("idle_hold_rcvd", rcvd_bt_cnt, 6);

    // Six 0s, sof on the first: sixth is a stuff bit.
    sof = 1'b1;
    for (int k = 1; k <= 5; k++) bit_in(1'b0, 1'b0, 0, k, 0, 0, 0, k);
    bit_in(1'b0, 1'b1, 0, 1, 0, 0, 0, 5);

`ifdef FIXED_STUFF_EN
    fix_stf_en = 1'b1;
    for (int k = 1; k <= 10; k++) bit_in(1'b0, 1'b0, 0, 0, 0, (k > 7) ? 7 : k, k, 5 + k);
    for (int k = 11; k <= 15; k++) bit_in(1'b1, 1'b0, 0, 0, k - 10, 0, k, 5 + k);
    chk("fix_bit_count_full", bit_count, 15);
    bit_in(1'b0, 1'b1, 0, 0, 5, 0, 0, 20);
    bit_in(1'b1, 1'b0, 0, 0, 6, 0, 1, 21);
    for (int k = 2; k <= 9; k++) bit_in(1'b1, 1'b0, 0, 0, 7, 0, k, 20 + k);
    chk("fix_bit_count_before_rst", bit_count, 9);
`else
    // fix_stf_en is ignored; dynamic stuffing continues.
    fix_stf_en = 1'b1;
    for (int k = 1; k <= 5; k++) bit_in(1'b1, 1'b0, k, 0, 0, 0, 0, 5 + k);
    bit_in(1'b1, 1'b1, 1, 0, 0, 0, 0, 10);
    chk("nofix_bit_count", bit_count, 0);
`endif

    // Asynchronous reset mid-frame.
    @(negedge clk); #2;
    g_rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    g_rst_n = 1'b1;
    bit_valid = 1'b1; serial_in = 1'b0;
    idle_cycles(2);
    bit_valid = 1'b0;
    idle_cycles(1);
    chk("idle_after_reset", all_outs(), 64'd0);

    // sof coincident with a 0, then a long alternating run into saturation.
    fix_stf_en = 1'b0; sof = 1'b1;
    bit_in(1'b0, 1'b0, 0, 1, 0, 0, 0, 1);
    for (int i = 2; i <= 32770; i++) begin
      logic b;
      b = (i % 2 == 0);
      bit_in(b, 1'b0, b ? 1 : 0, b ? 0 : 1, 0, 0, 0, (i > 32767) ? 32767 : i);
    end
    idle_cycles(1);
    chk("rcvd_saturated", rcvd_bt_cnt, 15'h7fff);
    frame_end = 1'b1;
    idle_cycles(1);
    frame_end = 1'b0;

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) idle_cycles(1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
